// File: rtl/sram_access_ctrl_pkg.sv
// Shared types for the i-cache SRAM access controller.
//   sram_ctrl_state_e : controller state (INIT sweep after reset, IDLE, FLUSH sweep)
//   wsrc_e            : write-port requester identity (fill or single-set invalidate)
//   other_wsrc()      : returns the opposite requester, used to advance the
//                       round-robin priority after a contended grant
package icache_sram_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } sram_ctrl_state_e;

  typedef enum logic {
    WSRC_FILL = 1'b0,
    WSRC_INV  = 1'b1
  } wsrc_e;

  function automatic wsrc_e other_wsrc(input wsrc_e src);
    return (src == WSRC_FILL) ? WSRC_INV : WSRC_FILL;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Bus between the access controller and one sram_template wrapper.
//   r_req_valid / r_req_setid : read request to the wrapper
//   r_resp_data               : read data from the wrapper (way k at [k*GEN_WIDTH +: GEN_WIDTH])
//   w_req_valid / w_req_setid / w_req_waymask / w_req_data : write request to the wrapper
// Modports: master = controller side, slave = wrapper side.
interface sram_access_ctrl_if #(
  parameter int GEN_WIDTH = 32,
  parameter int NUM_WAY   = 2,
  parameter int SET_DEPTH = 5
);

  logic                           r_req_valid;
  logic [SET_DEPTH-1:0]           r_req_setid;
  logic [NUM_WAY*GEN_WIDTH-1:0]   r_resp_data;
  logic                           w_req_valid;
  logic [SET_DEPTH-1:0]           w_req_setid;
  logic [NUM_WAY-1:0]             w_req_waymask;
  logic [NUM_WAY*GEN_WIDTH-1:0]   w_req_data;

  modport master (
    output r_req_valid,
    output r_req_setid,
    input  r_resp_data,
    output w_req_valid,
    output w_req_setid,
    output w_req_waymask,
    output w_req_data
  );

  modport slave (
    input  r_req_valid,
    input  r_req_setid,
    output r_resp_data,
    input  w_req_valid,
    input  w_req_setid,
    input  w_req_waymask,
    input  w_req_data
  );

endinterface

// File: rtl/sram_access_ctrl_rr_arb2.sv
// Two-input round-robin arbiter for the shared SRAM write port.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : arbitration allowed this cycle (controller is IDLE)
//   req_fill, req_inv   : requests from the refill and invalidate paths
//   grant_fill, grant_inv : combinational one-hot grants
// A lone requester always wins. Under contention the requester held in the
// priority register wins, and priority passes to the other side; uncontended
// grants leave the priority untouched.
module rr_arb2
  import icache_sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_fill,
  input  logic req_inv,
  output logic grant_fill,
  output logic grant_inv
);

  wsrc_e prio_reg;
  logic  contend;

  assign contend    = en && req_fill && req_inv;
  assign grant_fill = en && req_fill && (!req_inv  || (prio_reg == WSRC_FILL));
  assign grant_inv  = en && req_inv  && (!req_fill || (prio_reg == WSRC_INV));

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= WSRC_FILL;
    end else if (contend) begin
      prio_reg <= other_wsrc(prio_reg);
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Front-end scheduler for one i-cache SRAM (tag or data array).
//   clk, rst        : clock, synchronous active-high reset
//   flush_*         : full-array invalidation sweep request / busy / done pulse
//   rd_*            : fetch read port (accept when valid && ready, response one
//                     cycle later, data passed through from the wrapper)
//   fill_*          : refill write requester
//   inv_*           : single-set invalidate requester (writes zeros to masked ways)
//   sram            : master side of the bus to the SRAM wrapper
// After reset (INIT) and on a flush request (FLUSH) every set is written with
// all-zero data over NUM_SET consecutive cycles; all requesters are held off
// meanwhile. In IDLE the write port is shared round-robin between fill and inv.
module sram_access_ctrl
  import icache_sram_pkg::*;
#(
  parameter int GEN_WIDTH = 32,
  parameter int NUM_SET   = 32,
  parameter int NUM_WAY   = 2,
  parameter int SET_DEPTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_req_i,
  output logic                          flush_busy_o,
  output logic                          flush_done_o,
  input  logic                          rd_valid_i,
  input  logic [SET_DEPTH-1:0]          rd_setid_i,
  output logic                          rd_ready_o,
  output logic                          rd_resp_valid_o,
  output logic [NUM_WAY*GEN_WIDTH-1:0]  rd_resp_data_o,
  input  logic                          fill_valid_i,
  input  logic [SET_DEPTH-1:0]          fill_setid_i,
  input  logic [NUM_WAY-1:0]            fill_waymask_i,
  input  logic [NUM_WAY*GEN_WIDTH-1:0]  fill_data_i,
  output logic                          fill_ready_o,
  input  logic                          inv_valid_i,
  input  logic [SET_DEPTH-1:0]          inv_setid_i,
  input  logic [NUM_WAY-1:0]            inv_waymask_i,
  output logic                          inv_ready_o,
  sram_access_ctrl_if.master            sram
);

  localparam logic [SET_DEPTH-1:0] LAST_SET = SET_DEPTH'(NUM_SET - 1);

  sram_ctrl_state_e               state_reg;
  logic [SET_DEPTH-1:0]           sweep_cnt_reg;
  logic                           done_reg;
  logic                           resp_valid_reg;

  logic                           idle;
  logic                           sweeping;
  logic                           rd_accept;
  logic                           grant_fill;
  logic                           grant_inv;

  logic                           w_valid;
  logic [SET_DEPTH-1:0]           w_setid;
  logic [NUM_WAY-1:0]             w_waymask;
  logic [NUM_WAY*GEN_WIDTH-1:0]   w_data;

  // Every handshake output is forced low while rst is held, including the
  // registered pulses, so a pending response never leaks into the reset cycle.
  assign idle     = (state_reg == IDLE) && !rst;
  assign sweeping = (state_reg != IDLE) && !rst;

  assign flush_busy_o    = rst || (state_reg != IDLE);
  assign flush_done_o    = done_reg && !rst;
  assign rd_ready_o      = idle;
  assign rd_accept       = rd_valid_i && idle;
  assign rd_resp_valid_o = resp_valid_reg && !rst;
  // The wrapper's read latency is one cycle, so its output is already aligned
  // with rd_resp_valid_o; same-set write bypass happens inside the wrapper.
  assign rd_resp_data_o  = sram.r_resp_data;

  assign sram.r_req_valid = rd_accept;
  assign sram.r_req_setid = rd_setid_i;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (idle),
    .req_fill   (fill_valid_i),
    .req_inv    (inv_valid_i),
    .grant_fill (grant_fill),
    .grant_inv  (grant_inv)
  );

  assign fill_ready_o = grant_fill;
  assign inv_ready_o  = grant_inv;

  // Write-port mux: sweep owns the port outright; otherwise the arbiter winner
  // drives it. Grants are already zero outside IDLE.
  always_comb begin
    w_valid   = 1'b0;
    w_setid   = '0;
    w_waymask = '0;
    w_data    = '0;
    if (sweeping) begin
      w_valid   = 1'b1;
      w_setid   = sweep_cnt_reg;
      w_waymask = '1;
    end else if (grant_fill) begin
      w_valid   = 1'b1;
      w_setid   = fill_setid_i;
      w_waymask = fill_waymask_i;
      w_data    = fill_data_i;
    end else if (grant_inv) begin
      w_valid   = 1'b1;
      w_setid   = inv_setid_i;
      w_waymask = inv_waymask_i;
    end
  end

  assign sram.w_req_valid   = w_valid;
  assign sram.w_req_setid   = w_setid;
  assign sram.w_req_waymask = w_waymask;
  assign sram.w_req_data    = w_data;

  // Controller FSM with registered sweep counter, done pulse and read-response valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT;
      sweep_cnt_reg  <= '0;
      done_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
    end else begin
      done_reg       <= 1'b0;
      resp_valid_reg <= rd_accept;
      case (state_reg)
        INIT, FLUSH: begin
          if (sweep_cnt_reg == LAST_SET) begin
            state_reg     <= IDLE;
            sweep_cnt_reg <= '0;
            done_reg      <= 1'b1;
          end else begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (flush_req_i) begin
            state_reg <= FLUSH;
          end
        end
        default: begin
          state_reg     <= INIT;
          sweep_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: directed reset/flush/abort
// sequences, a table of IDLE vectors with hand-written expectations, and a
// randomized run checked cycle by cycle against a behavioural model.
module tb_sram_access_ctrl;

  localparam int GW = 32;
  localparam int NS = 32;
  localparam int NW = 2;
  localparam int SD = 5;
  localparam int DW = NW * GW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req_i;
  logic          flush_busy_o;
  logic          flush_done_o;
  logic          rd_valid_i;
  logic [SD-1:0] rd_setid_i;
  logic          rd_ready_o;
  logic          rd_resp_valid_o;
  logic [DW-1:0] rd_resp_data_o;
  logic          fill_valid_i;
  logic [SD-1:0] fill_setid_i;
  logic [NW-1:0] fill_waymask_i;
  logic [DW-1:0] fill_data_i;
  logic          fill_ready_o;
  logic          inv_valid_i;
  logic [SD-1:0] inv_setid_i;
  logic [NW-1:0] inv_waymask_i;
  logic          inv_ready_o;

  always #5 clk = ~clk;

  sram_access_ctrl_if #(.GEN_WIDTH(GW), .NUM_WAY(NW), .SET_DEPTH(SD)) sram_bus ();

  sram_access_ctrl #(.GEN_WIDTH(GW), .NUM_SET(NS), .NUM_WAY(NW), .SET_DEPTH(SD)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req_i     (flush_req_i),
    .flush_busy_o    (flush_busy_o),
    .flush_done_o    (flush_done_o),
    .rd_valid_i      (rd_valid_i),
    .rd_setid_i      (rd_setid_i),
    .rd_ready_o      (rd_ready_o),
    .rd_resp_valid_o (rd_resp_valid_o),
    .rd_resp_data_o  (rd_resp_data_o),
    .fill_valid_i    (fill_valid_i),
    .fill_setid_i    (fill_setid_i),
    .fill_waymask_i  (fill_waymask_i),
    .fill_data_i     (fill_data_i),
    .fill_ready_o    (fill_ready_o),
    .inv_valid_i     (inv_valid_i),
    .inv_setid_i     (inv_setid_i),
    .inv_waymask_i   (inv_waymask_i),
    .inv_ready_o     (inv_ready_o),
    .sram            (sram_bus)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          rd_valid;
    logic [SD-1:0] rd_set;
    logic          fill_valid;
    logic [SD-1:0] fill_set;
    logic [NW-1:0] fill_mask;
    logic [DW-1:0] fill_data;
    logic          inv_valid;
    logic [SD-1:0] inv_set;
    logic [NW-1:0] inv_mask;
    logic [DW-1:0] resp_data;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          e_rd_ready;
    logic          e_r_valid;
    logic          e_fill_ready;
    logic          e_inv_ready;
    logic          e_w_valid;
    logic [SD-1:0] e_w_set;
    logic [NW-1:0] e_w_mask;
    logic [DW-1:0] e_w_data;
    logic          e_resp_valid;
    logic [DW-1:0] e_resp_data;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: where the sweep is (-1 = not sweeping), pending
  // one-cycle pulses, and whose turn it is when both writers contend.
  int m_sweep    = 0;
  bit m_done     = 1'b0;
  bit m_resp     = 1'b0;
  bit m_inv_turn = 1'b0;
  bit m_accept   = 1'b0;
  bit m_contend  = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t st(input logic rd_v, input logic [SD-1:0] rd_s,
                               input logic f_v, input logic [SD-1:0] f_s,
                               input logic [NW-1:0] f_m, input logic [DW-1:0] f_d,
                               input logic i_v, input logic [SD-1:0] i_s,
                               input logic [NW-1:0] i_m, input logic [DW-1:0] resp);
    stim_t s;
    s.rst = 1'b0;        s.flush = 1'b0;
    s.rd_valid = rd_v;   s.rd_set = rd_s;
    s.fill_valid = f_v;  s.fill_set = f_s;  s.fill_mask = f_m;  s.fill_data = f_d;
    s.inv_valid = i_v;   s.inv_set = i_s;   s.inv_mask = i_m;
    s.resp_data = resp;
    return s;
  endfunction

  function automatic stim_t quiet();
    return st(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, '0, {$urandom, $urandom});
  endfunction

  function automatic vec_t row(input stim_t s, input logic rdy, input logic rv,
                               input logic fr, input logic ir, input logic wv,
                               input logic [SD-1:0] ws, input logic [NW-1:0] wm,
                               input logic [DW-1:0] wd, input logic respv,
                               input logic [DW-1:0] respd);
    vec_t v;
    v.s = s;
    v.e_rd_ready = rdy;  v.e_r_valid = rv;
    v.e_fill_ready = fr; v.e_inv_ready = ir;
    v.e_w_valid = wv;    v.e_w_set = ws;  v.e_w_mask = wm;  v.e_w_data = wd;
    v.e_resp_valid = respv; v.e_resp_data = respd;
    return v;
  endfunction

  // Compare every DUT output against what the model says this cycle should show.
  task automatic check_model();
    logic          ex_busy, ex_rdy, ex_rv, ex_fr, ex_ir, ex_wv, ex_resp, ex_done;
    logic [SD-1:0] ex_ws;
    logic [NW-1:0] ex_wm;
    logic [DW-1:0] ex_wd;
    ex_rdy = 1'b0; ex_rv = 1'b0; ex_fr = 1'b0; ex_ir = 1'b0; ex_wv = 1'b0;
    ex_resp = 1'b0; ex_done = 1'b0; ex_ws = '0; ex_wm = '0; ex_wd = '0;
    ex_busy = rst || (m_sweep >= 0);
    if (!rst) begin
      ex_done = m_done;
      ex_resp = m_resp;
      if (m_sweep >= 0) begin
        ex_wv = 1'b1;
        ex_ws = SD'(m_sweep);
        ex_wm = '1;
      end else begin
        ex_rdy = 1'b1;
        ex_rv  = rd_valid_i;
        if (fill_valid_i && inv_valid_i) begin
          ex_fr = !m_inv_turn;
          ex_ir = m_inv_turn;
        end else begin
          ex_fr = fill_valid_i;
          ex_ir = inv_valid_i;
        end
        if (ex_fr) begin
          ex_wv = 1'b1; ex_ws = fill_setid_i; ex_wm = fill_waymask_i; ex_wd = fill_data_i;
        end else if (ex_ir) begin
          ex_wv = 1'b1; ex_ws = inv_setid_i; ex_wm = inv_waymask_i;
        end
      end
    end
    m_accept  = ex_rv;
    m_contend = !rst && (m_sweep < 0) && fill_valid_i && inv_valid_i;
    chk("m_busy",       DW'(flush_busy_o),    DW'(ex_busy));
    chk("m_done",       DW'(flush_done_o),    DW'(ex_done));
    chk("m_rd_ready",   DW'(rd_ready_o),      DW'(ex_rdy));
    chk("m_r_valid",    DW'(sram_bus.r_req_valid), DW'(ex_rv));
    chk("m_fill_ready", DW'(fill_ready_o),    DW'(ex_fr));
    chk("m_inv_ready",  DW'(inv_ready_o),     DW'(ex_ir));
    chk("m_w_valid",    DW'(sram_bus.w_req_valid), DW'(ex_wv));
    chk("m_resp_valid", DW'(rd_resp_valid_o), DW'(ex_resp));
    if (ex_rv) chk("m_r_setid", DW'(sram_bus.r_req_setid), DW'(rd_setid_i));
    if (ex_wv) begin
      chk("m_w_setid", DW'(sram_bus.w_req_setid),   DW'(ex_ws));
      chk("m_w_mask",  DW'(sram_bus.w_req_waymask), DW'(ex_wm));
      chk("m_w_data",  sram_bus.w_req_data,         ex_wd);
    end
    if (ex_resp) chk("m_resp_data", rd_resp_data_o, sram_bus.r_resp_data);
  endtask

  task automatic apply(input stim_t s);
    rst            = s.rst;
    flush_req_i    = s.flush;
    rd_valid_i     = s.rd_valid;
    rd_setid_i     = s.rd_set;
    fill_valid_i   = s.fill_valid;
    fill_setid_i   = s.fill_set;
    fill_waymask_i = s.fill_mask;
    fill_data_i    = s.fill_data;
    inv_valid_i    = s.inv_valid;
    inv_setid_i    = s.inv_set;
    inv_waymask_i  = s.inv_mask;
    sram_bus.r_resp_data = s.resp_data;
    #2;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_sweep = 0; m_done = 1'b0; m_resp = 1'b0; m_inv_turn = 1'b0;
    end else begin
      m_resp = m_accept;
      m_done = 1'b0;
      if (m_contend) m_inv_turn = !m_inv_turn;
      if (m_sweep >= 0) begin
        if (m_sweep == NS - 1) begin
          m_sweep = -1;
          m_done  = 1'b1;
        end else begin
          m_sweep++;
        end
      end else if (flush_req_i) begin
        m_sweep = 0;
      end
    end
    #2;
  endtask

  localparam logic [DW-1:0] RD5  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [DW-1:0] RD9  = 64'h0909_0909_F00D_CAFE;
  localparam logic [DW-1:0] FD1  = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] FD9  = 64'hA5A5_A5A5_5A5A_5A5A;
  localparam logic [DW-1:0] FD20 = 64'h2020_2020_0000_0020;
  localparam int NT = 13;

  initial begin
    vec_t  tbl [NT];
    stim_t s;
    int    writes, dones;
    logic  pf_v, pi_v, got_f, got_i, got_r;
    logic [SD-1:0] pf_s, pi_s;
    logic [NW-1:0] pf_m, pi_m;
    logic [DW-1:0] pf_d;

    // ---------------- reset and the power-up sweep ----------------
    s = quiet(); s.rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(s);
      chk("rst_busy", DW'(flush_busy_o), 1);
      chk("rst_w_valid", DW'(sram_bus.w_req_valid), 0);
      chk("rst_rd_ready", DW'(rd_ready_o), 0);
      tick();
    end
    writes = 0;
    for (int k = 1; k <= 34; k++) begin
      s = quiet();
      s.rd_valid = (k == 20);
      s.rd_set   = 5'd5;
      apply(s);
      if (sram_bus.w_req_valid) writes++;
      if (k <= 32) begin
        chk("init_w_setid", DW'(sram_bus.w_req_setid), DW'(k - 1));
        chk("init_rd_ready", DW'(rd_ready_o), 0);
        chk("init_done_low", DW'(flush_done_o), 0);
      end
      if (k == 20) chk("init_r_valid_blocked", DW'(sram_bus.r_req_valid), 0);
      if (k == 33) begin
        chk("init_done_pulse", DW'(flush_done_o), 1);
        chk("init_rd_ready_up", DW'(rd_ready_o), 1);
      end
      tick();
    end
    chk("init_write_count", DW'(writes), DW'(NS));
    $display("init sweep: %0d writes observed", writes);

    // ---------------- IDLE vector table ----------------
    tbl[0]  = row(st(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, RD5),       1, 1, 0, 0, 0, 0,     0,     0,   0, 0);
    tbl[1]  = row(st(0, 0, 0, 0, 0, 0, 0, 0, 0, RD5),          1, 0, 0, 0, 0, 0,     0,     0,   1, RD5);
    tbl[2]  = row(st(0, 0, 1, 5'd3, 2'b01, FD1, 1, 5'd7, 2'b10, 0), 1, 0, 1, 0, 1, 5'd3, 2'b01, FD1, 0, 0);
    tbl[3]  = row(st(0, 0, 1, 5'd3, 2'b01, FD1, 1, 5'd7, 2'b10, 0), 1, 0, 0, 1, 1, 5'd7, 2'b10, 0,   0, 0);
    tbl[4]  = row(st(0, 0, 1, 5'd3, 2'b01, FD1, 1, 5'd7, 2'b10, 0), 1, 0, 1, 0, 1, 5'd3, 2'b01, FD1, 0, 0);
    tbl[5]  = row(st(0, 0, 1, 5'd3, 2'b01, FD1, 1, 5'd7, 2'b10, 0), 1, 0, 0, 1, 1, 5'd7, 2'b10, 0,   0, 0);
    tbl[6]  = row(st(1, 5'd9, 1, 5'd9, 2'b11, FD9, 0, 0, 0, RD9),  1, 1, 1, 0, 1, 5'd9, 2'b11, FD9, 0, 0);
    tbl[7]  = row(st(0, 0, 0, 0, 0, 0, 0, 0, 0, RD9),          1, 0, 0, 0, 0, 0,     0,     0,   1, RD9);
    tbl[8]  = row(st(0, 0, 0, 0, 0, 0, 1, 5'd12, 2'b01, 0),    1, 0, 0, 1, 1, 5'd12, 2'b01, 0,   0, 0);
    tbl[9]  = row(st(0, 0, 1, 5'd20, 2'b10, FD20, 0, 0, 0, 0), 1, 0, 1, 0, 1, 5'd20, 2'b10, FD20, 0, 0);
    tbl[10] = row(st(0, 0, 1, 5'd1, 2'b11, FD1, 1, 5'd2, 2'b11, 0), 1, 0, 1, 0, 1, 5'd1, 2'b11, FD1, 0, 0);
    tbl[11] = row(st(0, 0, 0, 0, 0, 0, 1, 5'd4, 2'b01, 0),     1, 0, 0, 1, 1, 5'd4, 2'b01, 0,   0, 0);
    tbl[12] = row(st(0, 0, 1, 5'd1, 2'b11, FD1, 1, 5'd2, 2'b11, 0), 1, 0, 0, 1, 1, 5'd2, 2'b11, 0,   0, 0);

    for (int i = 0; i < NT; i++) begin
      apply(tbl[i].s);
      chk($sformatf("tbl%0d_rd_ready", i),   DW'(rd_ready_o),           DW'(tbl[i].e_rd_ready));
      chk($sformatf("tbl%0d_r_valid", i),    DW'(sram_bus.r_req_valid), DW'(tbl[i].e_r_valid));
      chk($sformatf("tbl%0d_fill_ready", i), DW'(fill_ready_o),         DW'(tbl[i].e_fill_ready));
      chk($sformatf("tbl%0d_inv_ready", i),  DW'(inv_ready_o),          DW'(tbl[i].e_inv_ready));
      chk($sformatf("tbl%0d_w_valid", i),    DW'(sram_bus.w_req_valid), DW'(tbl[i].e_w_valid));
      chk($sformatf("tbl%0d_resp_valid", i), DW'(rd_resp_valid_o),      DW'(tbl[i].e_resp_valid));
      if (tbl[i].e_w_valid) begin
        chk($sformatf("tbl%0d_w_setid", i), DW'(sram_bus.w_req_setid),   DW'(tbl[i].e_w_set));
        chk($sformatf("tbl%0d_w_mask", i),  DW'(sram_bus.w_req_waymask), DW'(tbl[i].e_w_mask));
        chk($sformatf("tbl%0d_w_data", i),  sram_bus.w_req_data,         tbl[i].e_w_data);
      end
      if (tbl[i].e_r_valid)
        chk($sformatf("tbl%0d_r_setid", i), DW'(sram_bus.r_req_setid), DW'(tbl[i].s.rd_set));
      if (tbl[i].e_resp_valid)
        chk($sformatf("tbl%0d_resp_data", i), rd_resp_data_o, tbl[i].e_resp_data);
      $display("vector %0d: fill_ready=%b inv_ready=%b w_setid=%0d r_valid=%b resp_valid=%b",
               i, fill_ready_o, inv_ready_o, sram_bus.w_req_setid, sram_bus.r_req_valid,
               rd_resp_valid_o);
      tick();
    end

    // ---------------- flush concurrent with fill, second flush ignored ----------------
    s = st(0, 0, 1, 5'd4, 2'b11, FD1, 0, 0, 0, 0);
    s.flush = 1'b1;
    apply(s);
    chk("flush_fill_ready", DW'(fill_ready_o), 1);
    chk("flush_fill_setid", DW'(sram_bus.w_req_setid), 4);
    tick();
    writes = 0; dones = 0;
    for (int k = 1; k <= 40; k++) begin
      s = quiet();
      s.flush      = (k == 10);
      s.fill_valid = (k < 5);
      s.fill_set   = 5'd6;
      apply(s);
      if (sram_bus.w_req_valid) writes++;
      if (flush_done_o) dones++;
      if (k < 5) chk("flush_fill_held_off", DW'(fill_ready_o), 0);
      tick();
    end
    chk("flush_write_count", DW'(writes), DW'(NS));
    chk("flush_done_count", DW'(dones), 1);
    $display("flush sweep: %0d writes, %0d done pulses", writes, dones);

    // ---------------- reset in the middle of a sweep ----------------
    s = quiet(); s.flush = 1'b1;
    apply(s);
    tick();
    dones = 0;
    for (int k = 1; k <= 17; k++) begin
      apply(quiet());
      chk("abort_w_setid", DW'(sram_bus.w_req_setid), DW'(k - 1));
      if (flush_done_o) dones++;
      tick();
    end
    s = quiet(); s.rst = 1'b1;
    apply(s);
    chk("abort_rst_w_valid", DW'(sram_bus.w_req_valid), 0);
    tick();
    writes = 0;
    for (int k = 1; k <= 34; k++) begin
      apply(quiet());
      if (sram_bus.w_req_valid) writes++;
      if (k == 1) chk("abort_restart_set0", DW'(sram_bus.w_req_setid), 0);
      if (k < 33 && flush_done_o) dones++;
      if (k == 33) chk("abort_done_after_restart", DW'(flush_done_o), 1);
      tick();
    end
    chk("abort_no_done", DW'(dones), 0);
    chk("abort_write_count", DW'(writes), DW'(NS));
    $display("abort: restart sweep %0d writes", writes);

    // ---------------- randomized traffic against the model ----------------
    pf_v = 1'b0; pi_v = 1'b0;
    pf_s = '0; pi_s = '0; pf_m = '0; pi_m = '0; pf_d = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pf_v && $urandom_range(1, 0) == 1) begin
        pf_v = 1'b1; pf_s = SD'($urandom); pf_m = NW'($urandom); pf_d = {$urandom, $urandom};
      end
      if (!pi_v && $urandom_range(2, 0) == 0) begin
        pi_v = 1'b1; pi_s = SD'($urandom); pi_m = NW'($urandom);
      end
      s = st(1'($urandom_range(1, 0)), SD'($urandom), pf_v, pf_s, pf_m, pf_d,
             pi_v, pi_s, pi_m, {$urandom, $urandom});
      s.rst   = ($urandom_range(249, 0) == 0);
      s.flush = ($urandom_range(39, 0) == 0);
      apply(s);
      got_f = fill_ready_o;
      got_i = inv_ready_o;
      got_r = rd_valid_i && rd_ready_o;
      if (got_f || got_i || got_r)
        $display("rand %0d: fill=%b inv=%b rd=%b w_setid=%0d r_setid=%0d",
                 c, got_f, got_i, got_r, sram_bus.w_req_setid, sram_bus.r_req_setid);
      if (got_f) pf_v = 1'b0;
      if (got_i) pi_v = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
